// File: rtl/reg_file_sb.sv
// Dual-write, dual-read register file with a per-register busy scoreboard.
// Decode claims destination registers; writeback (ALU on port 0, load on port 1) releases them.
module reg_file_sb #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int ZERO_REG   = 0,
    parameter int BYPASS     = 1
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Wr_En0,
    input  logic [ADDR_WIDTH-1:0] Wr_Addr0,
    input  logic [DATA_WIDTH-1:0] Wr_Data0,
    input  logic                  Wr_En1,
    input  logic [ADDR_WIDTH-1:0] Wr_Addr1,
    input  logic [DATA_WIDTH-1:0] Wr_Data1,
    input  logic                  Rd_En,
    input  logic [ADDR_WIDTH-1:0] Source_Reg1,
    input  logic [ADDR_WIDTH-1:0] Source_Reg2,
    input  logic                  Claim_En,
    input  logic [ADDR_WIDTH-1:0] Claim_Addr,
    output logic [DATA_WIDTH-1:0] Reg1_Out,
    output logic [DATA_WIDTH-1:0] Reg2_Out,
    output logic                  Reg1_Busy,
    output logic                  Reg2_Busy,
    output logic                  Any_Busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;
    logic [DATA_WIDTH-1:0] rd1_q, rd1_d;
    logic [DATA_WIDTH-1:0] rd2_q, rd2_d;
    logic                  rb1_q, rb1_d;
    logic                  rb2_q, rb2_d;

    logic wr0_ok, wr1_ok, claim_ok;

    // Address 0 is immune to writes and claims when it is hardwired to zero.
    always_comb begin
        wr0_ok   = Wr_En0;
        wr1_ok   = Wr_En1;
        claim_ok = Claim_En;
        if (ZERO_REG != 0) begin
            if (Wr_Addr0 == '0)   wr0_ok   = 1'b0;
            if (Wr_Addr1 == '0)   wr1_ok   = 1'b0;
            if (Claim_Addr == '0) claim_ok = 1'b0;
        end
    end

    // Port 1 is applied last so it wins a same-address collision.
    always_comb begin
        regs_d = regs_q;
        if (wr0_ok) regs_d[Wr_Addr0] = Wr_Data0;
        if (wr1_ok) regs_d[Wr_Addr1] = Wr_Data1;
    end

    // Claim is applied after the clears: a new claim outranks a same-cycle writeback.
    always_comb begin
        busy_d = busy_q;
        if (wr0_ok)   busy_d[Wr_Addr0]   = 1'b0;
        if (wr1_ok)   busy_d[Wr_Addr1]   = 1'b0;
        if (claim_ok) busy_d[Claim_Addr] = 1'b1;
    end

    always_comb begin
        rd1_d = rd1_q;
        rd2_d = rd2_q;
        rb1_d = rb1_q;
        rb2_d = rb2_q;
        if (Rd_En) begin
            if (BYPASS != 0) begin
                rd1_d = regs_d[Source_Reg1];
                rd2_d = regs_d[Source_Reg2];
            end else begin
                rd1_d = regs_q[Source_Reg1];
                rd2_d = regs_q[Source_Reg2];
            end
            // Busy flags always see the post-edge scoreboard.
            rb1_d = busy_d[Source_Reg1];
            rb2_d = busy_d[Source_Reg2];
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            busy_q <= '0;
            rd1_q  <= '0;
            rd2_q  <= '0;
            rb1_q  <= 1'b0;
            rb2_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            rb1_q  <= rb1_d;
            rb2_q  <= rb2_d;
        end
    end

    assign Reg1_Out  = rd1_q;
    assign Reg2_Out  = rd2_q;
    assign Reg1_Busy = rb1_q;
    assign Reg2_Busy = rb2_q;
    assign Any_Busy  = |busy_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: instance a is the default build (bypass, no zero register),
// instance b has bypass disabled and register 0 hardwired to zero. Both share all inputs.
module tb_reg_file_sb;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       Wr_En0, Wr_En1, Rd_En, Claim_En;
    logic [2:0] Wr_Addr0, Wr_Addr1, Source_Reg1, Source_Reg2, Claim_Addr;
    logic [7:0] Wr_Data0, Wr_Data1;

    logic [7:0] a_r1, a_r2, b_r1, b_r2;
    logic       a_b1, a_b2, a_any, b_b1, b_b2, b_any;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    reg_file_sb #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG(0), .BYPASS(1)) dut_a (
        .Clk(Clk), .Rst_n(Rst_n),
        .Wr_En0(Wr_En0), .Wr_Addr0(Wr_Addr0), .Wr_Data0(Wr_Data0),
        .Wr_En1(Wr_En1), .Wr_Addr1(Wr_Addr1), .Wr_Data1(Wr_Data1),
        .Rd_En(Rd_En), .Source_Reg1(Source_Reg1), .Source_Reg2(Source_Reg2),
        .Claim_En(Claim_En), .Claim_Addr(Claim_Addr),
        .Reg1_Out(a_r1), .Reg2_Out(a_r2), .Reg1_Busy(a_b1), .Reg2_Busy(a_b2), .Any_Busy(a_any)
    );

    reg_file_sb #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .Clk(Clk), .Rst_n(Rst_n),
        .Wr_En0(Wr_En0), .Wr_Addr0(Wr_Addr0), .Wr_Data0(Wr_Data0),
        .Wr_En1(Wr_En1), .Wr_Addr1(Wr_Addr1), .Wr_Data1(Wr_Data1),
        .Rd_En(Rd_En), .Source_Reg1(Source_Reg1), .Source_Reg2(Source_Reg2),
        .Claim_En(Claim_En), .Claim_Addr(Claim_Addr),
        .Reg1_Out(b_r1), .Reg2_Out(b_r2), .Reg1_Busy(b_b1), .Reg2_Busy(b_b2), .Any_Busy(b_any)
    );

    task automatic idle();
        Wr_En0 = 0; Wr_Addr0 = 0; Wr_Data0 = 0;
        Wr_En1 = 0; Wr_Addr1 = 0; Wr_Data1 = 0;
        Rd_En = 0; Source_Reg1 = 0; Source_Reg2 = 0;
        Claim_En = 0; Claim_Addr = 0;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        Wr_En0 = 1; Wr_Addr0 = 3; Wr_Data0 = 8'hAA; Rd_En = 1; Source_Reg1 = 3;
        step();
        n_cmp++; if (a_r1 !== 8'hAA) begin n_err++; $display("FAIL reset_pre_a_r1 got %h want aa", a_r1); end
        idle();
        #3 Rst_n = 0;
        #1;
        n_cmp++; if (a_r1 !== 8'h00) begin n_err++; $display("FAIL reset_async_a_r1 got %h want 00", a_r1); end
        n_cmp++; if (b_r1 !== 8'h00) begin n_err++; $display("FAIL reset_async_b_r1 got %h want 00", b_r1); end
        #2 Rst_n = 1;
        Rd_En = 1; Source_Reg1 = 3; Source_Reg2 = 3;
        step();
        n_cmp++; if (a_r1 !== 8'h00) begin n_err++; $display("FAIL reset_r3_a got %h want 00", a_r1); end
        n_cmp++; if (b_r2 !== 8'h00) begin n_err++; $display("FAIL reset_r3_b got %h want 00", b_r2); end
        n_cmp++; if ({a_b1, a_any, b_b1, b_any} !== 4'b0000) begin n_err++; $display("FAIL reset_busy got %b want 0000", {a_b1, a_any, b_b1, b_any}); end
    endtask

    task automatic test_basic();
        idle();
        Wr_En0 = 1; Wr_Addr0 = 5; Wr_Data0 = 8'h3C;
        step();
        idle();
        Rd_En = 1; Source_Reg1 = 5; Source_Reg2 = 5;
        step();
        n_cmp++; if ({a_r1, a_r2} !== 16'h3C3C) begin n_err++; $display("FAIL basic_read_a got %h want 3c3c", {a_r1, a_r2}); end
        n_cmp++; if ({b_r1, b_r2} !== 16'h3C3C) begin n_err++; $display("FAIL basic_read_b got %h want 3c3c", {b_r1, b_r2}); end
        Rd_En = 0; Source_Reg1 = 1; Source_Reg2 = 3;
        step();
        n_cmp++; if ({a_r1, a_r2} !== 16'h3C3C) begin n_err++; $display("FAIL basic_hold_a got %h want 3c3c", {a_r1, a_r2}); end
        n_cmp++; if ({b_r1, b_r2} !== 16'h3C3C) begin n_err++; $display("FAIL basic_hold_b got %h want 3c3c", {b_r1, b_r2}); end
    endtask

    task automatic test_collision();
        idle();
        Wr_En0 = 1; Wr_Addr0 = 2; Wr_Data0 = 8'h11;
        Wr_En1 = 1; Wr_Addr1 = 2; Wr_Data1 = 8'h22;
        Rd_En = 1; Source_Reg1 = 2; Source_Reg2 = 5;
        step();
        n_cmp++; if (a_r1 !== 8'h22) begin n_err++; $display("FAIL coll_bypass_a got %h want 22", a_r1); end
        n_cmp++; if (b_r1 !== 8'h00) begin n_err++; $display("FAIL coll_nobypass_b got %h want 00", b_r1); end
        idle();
        Rd_En = 1; Source_Reg1 = 2; Source_Reg2 = 2;
        step();
        n_cmp++; if ({a_r1, b_r2} !== 16'h2222) begin n_err++; $display("FAIL coll_stored got %h want 2222", {a_r1, b_r2}); end
        idle();
        Wr_En0 = 1; Wr_Addr0 = 6; Wr_Data0 = 8'h66;
        Wr_En1 = 1; Wr_Addr1 = 7; Wr_Data1 = 8'h77;
        Rd_En = 1; Source_Reg1 = 6; Source_Reg2 = 7;
        step();
        n_cmp++; if ({a_r1, a_r2} !== 16'h6677) begin n_err++; $display("FAIL dual_bypass_a got %h want 6677", {a_r1, a_r2}); end
        n_cmp++; if ({b_r1, b_r2} !== 16'h0000) begin n_err++; $display("FAIL dual_old_b got %h want 0000", {b_r1, b_r2}); end
        idle();
        Rd_En = 1; Source_Reg1 = 6; Source_Reg2 = 7;
        step();
        n_cmp++; if ({b_r1, b_r2} !== 16'h6677) begin n_err++; $display("FAIL dual_stored_b got %h want 6677", {b_r1, b_r2}); end
    endtask

    task automatic test_zero_reg();
        idle();
        Wr_En0 = 1; Wr_Addr0 = 0; Wr_Data0 = 8'hFF;
        Claim_En = 1; Claim_Addr = 0;
        Rd_En = 1; Source_Reg1 = 0; Source_Reg2 = 0;
        step();
        n_cmp++; if ({b_r1, b_b1, b_any} !== 10'h000) begin n_err++; $display("FAIL zero_b got %h want 000", {b_r1, b_b1, b_any}); end
        n_cmp++; if ({a_r1, a_b1, a_any} !== {8'hFF, 2'b11}) begin n_err++; $display("FAIL zero_a got %h want 3ff", {a_r1, a_b1, a_any}); end
        idle();
        Rd_En = 1; Source_Reg1 = 0;
        step();
        n_cmp++; if (b_r1 !== 8'h00) begin n_err++; $display("FAIL zero_reread_b got %h want 00", b_r1); end
        n_cmp++; if (a_r1 !== 8'hFF) begin n_err++; $display("FAIL zero_reread_a got %h want ff", a_r1); end
        idle();
        Wr_En1 = 1; Wr_Addr1 = 0; Wr_Data1 = 8'h01;
        step();
        n_cmp++; if (a_any !== 1'b0) begin n_err++; $display("FAIL zero_release_a got %b want 0", a_any); end
    endtask

    task automatic test_scoreboard();
        idle();
        Claim_En = 1; Claim_Addr = 4; Rd_En = 1; Source_Reg1 = 4; Source_Reg2 = 3;
        step();
        n_cmp++; if ({a_b1, a_b2, a_any} !== 3'b101) begin n_err++; $display("FAIL sb_claim_a got %b want 101", {a_b1, a_b2, a_any}); end
        n_cmp++; if ({b_b1, b_b2, b_any} !== 3'b101) begin n_err++; $display("FAIL sb_claim_b got %b want 101", {b_b1, b_b2, b_any}); end
        idle();
        Wr_En0 = 1; Wr_Addr0 = 4; Wr_Data0 = 8'h44; Claim_En = 1; Claim_Addr = 4;
        Rd_En = 1; Source_Reg1 = 4;
        step();
        n_cmp++; if ({a_b1, a_any, a_r1} !== {2'b11, 8'h44}) begin n_err++; $display("FAIL sb_wr_claim_a got %h want 344", {a_b1, a_any, a_r1}); end
        n_cmp++; if ({b_b1, b_any, b_r1} !== {2'b11, 8'h00}) begin n_err++; $display("FAIL sb_wr_claim_b got %h want 300", {b_b1, b_any, b_r1}); end
        idle();
        Wr_En0 = 1; Wr_Addr0 = 4; Wr_Data0 = 8'h45; Rd_En = 1; Source_Reg1 = 4;
        step();
        n_cmp++; if ({a_b1, a_any, a_r1} !== {2'b00, 8'h45}) begin n_err++; $display("FAIL sb_release_a got %h want 045", {a_b1, a_any, a_r1}); end
        n_cmp++; if ({b_b1, b_any, b_r1} !== {2'b00, 8'h44}) begin n_err++; $display("FAIL sb_release_b got %h want 044", {b_b1, b_any, b_r1}); end
        idle();
        Claim_En = 1; Claim_Addr = 1; Source_Reg1 = 1;
        step();
        n_cmp++; if ({a_b1, a_any} !== 2'b01) begin n_err++; $display("FAIL sb_hold_a got %b want 01", {a_b1, a_any}); end
        idle();
        Wr_En1 = 1; Wr_Addr1 = 1; Wr_Data1 = 8'h5A; Rd_En = 1; Source_Reg2 = 1;
        step();
        n_cmp++; if ({a_b2, a_any, b_b2, b_any} !== 4'b0000) begin n_err++; $display("FAIL sb_port1_clear got %b want 0000", {a_b2, a_any, b_b2, b_any}); end
        n_cmp++; if (a_r2 !== 8'h5A) begin n_err++; $display("FAIL sb_port1_data_a got %h want 5a", a_r2); end
    endtask

    task automatic test_back_to_back();
        idle();
        Rd_En = 1;
        Wr_En0 = 1; Wr_Addr0 = 1; Wr_Data0 = 8'hA1; Source_Reg1 = 1;
        step();
        Wr_Addr0 = 2; Wr_Data0 = 8'hB2; Source_Reg1 = 2; Source_Reg2 = 1;
        step();
        n_cmp++; if ({a_r1, a_r2} !== 16'hB2A1) begin n_err++; $display("FAIL b2b_a got %h want b2a1", {a_r1, a_r2}); end
        n_cmp++; if ({b_r1, b_r2} !== 16'h22A1) begin n_err++; $display("FAIL b2b_b got %h want 22a1", {b_r1, b_r2}); end
        idle();
        Rd_En = 1; Source_Reg1 = 2; Source_Reg2 = 5;
        step();
        n_cmp++; if ({b_r1, b_r2} !== 16'hB23C) begin n_err++; $display("FAIL b2b_final_b got %h want b23c", {b_r1, b_r2}); end
    endtask

    initial begin
        idle();
        Rst_n = 0;
        #17 Rst_n = 1;
        test_reset();
        test_basic();
        test_collision();
        test_zero_reg();
        test_scoreboard();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the 8-entry, single-write CPU register file.
- 2^ADDR_WIDTH entries, two write ports with fixed priority, and two registered read ports with optional write-to-read bypass.
- Optional hardwired-zero register 0.
- Per-register busy scoreboard, so the control unit can detect RAW hazards on results not yet written back.
- Sits between the decode stage (read and claim) and writeback (ALU result on port 0, memory load on port 1).

Parameters:
DATA_WIDTH, 8, width of every register and data port
ADDR_WIDTH, 3, register address width; depth = 2**ADDR_WIDTH
ZERO_REG, 0, 1 = register 0 always reads 0, and writes/claims to it are ignored
BYPASS, 1, 1 = a read in the same cycle as a write to that address returns the new data

Ports:
Clk  in  1  clock, all state updates on rising edge
Rst_n  in  1  asynchronous active-low reset
Wr_En0  in  1  write port 0 enable
Wr_Addr0  in  ADDR_WIDTH  write port 0 address
Wr_Data0  in  DATA_WIDTH  write port 0 data
Wr_En1  in  1  write port 1 enable (higher priority)
Wr_Addr1  in  ADDR_WIDTH  write port 1 address
Wr_Data1  in  DATA_WIDTH  write port 1 data
Rd_En  in  1  read-port update enable; 0 holds both read outputs
Source_Reg1  in  ADDR_WIDTH  read address 1
Source_Reg2  in  ADDR_WIDTH  read address 2
Claim_En  in  1  mark Claim_Addr busy (instruction issued, result pending)
Claim_Addr  in  ADDR_WIDTH  register to mark busy
Reg1_Out  out  DATA_WIDTH  registered read data 1
Reg2_Out  out  DATA_WIDTH  registered read data 2
Reg1_Busy  out  1  registered busy flag for Source_Reg1
Reg2_Busy  out  1  registered busy flag for Source_Reg2
Any_Busy  out  1  combinational OR of all busy bits

Behaviour:
- Clocking and reset: one clock, Clk; reset Rst_n is asynchronous, active-low.
- Reset value: all registers, busy bits, Reg1_Out, Reg2_Out, Reg1_Busy and Reg2_Busy clear to 0 immediately on Rst_n low, independent of Clk.
- Reset mid-operation: reset discards any in-flight writes and claims; the first edge after deassertion behaves as normal.
- Writes: on the rising edge, the selected register takes the port's data.
  - Both ports enabled to the same address: port 1 data is stored, port 0 is dropped.
  - Different addresses: both writes occur.
- ZERO_REG=1: writes to address 0 are ignored, register 0 stays 0, and its busy bit is never set.
- Reads: latency 1 cycle.
  - When Rd_En=1, on each edge Reg1_Out/Reg2_Out load the entry at Source_Reg1/Source_Reg2.
  - When Rd_En=0, outputs hold.
  - Both ports may address the same register.
- Bypass, BYPASS=1: if an enabled write targets a read address in the same cycle, the output loads the write data (port 1 over port 0). The outputs therefore equal the post-edge register contents.
- Bypass, BYPASS=0: the read returns the pre-write value.
- Scoreboard update per edge, per address:
  - claim sets the busy bit;
  - any enabled write clears it;
  - claim and write to the same address in the same cycle: busy is set (the new claim wins).
- Busy outputs: when Rd_En=1, Reg1_Busy/Reg2_Busy load the post-edge busy value of their source address, always bypassed regardless of BYPASS. When Rd_En=0 they hold.
- Any_Busy: reflects the current busy bits (no extra latency after the edge).
- Address range: all addresses are in range by construction; there is no out-of-range case.

Test Plan:
- Reset: write 0xAA to r3, assert Rst_n=0 asynchronously mid-cycle → Reg1_Out=0 immediately; after release, read r3 → 0x00.
- Basic write/read: write r5=0x3C via port 0; next cycle Source_Reg1=5, Source_Reg2=5, Rd_En=1 → both outputs 0x3C one edge later; Rd_En=0 with a new address → outputs stay 0x3C.
- Write collision and bypass (BYPASS=1): in the same cycle port0 r2=0x11, port1 r2=0x22, Source_Reg1=2 → Reg1_Out=0x22 after that edge and r2 stores 0x22. Repeat with BYPASS=0 → Reg1_Out shows the old r2, and the next read gives 0x22.
- Zero register (ZERO_REG=1): write r0=0xFF and claim r0 → reads return 0x00, Reg1_Busy=0, Any_Busy=0.
- Scoreboard: claim r4 → Any_Busy=1, read r4 shows Reg1_Busy=1. Write r4 plus claim r4 in the same cycle → busy stays 1. Write r4 alone → busy 0, Any_Busy=0.
- Random regression, DATA_WIDTH=16, ADDR_WIDTH=5: random writes, claims, reads and Rd_En against a reference model for 10k cycles, with async resets injected → zero mismatches.
